// File: rtl/sap_ram_load_ctrl.sv
// SAP-1 program-RAM arbiter: steers the 157 address mux between the MAR and the
// manual switches, freezes the CPU while the loader owns the RAM, and times each manual write.
module sap_ram_load_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int WE_CYCLES = 2,
  parameter int SETTLE    = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              mode_req,
  input  logic              cpu_idle,
  output logic              cpu_hold,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              wr_req,
  output logic              wr_ack,
  output logic              mux_select,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we_n,
  output logic              mode_prog
);

  localparam int CNT_MAX = (WE_CYCLES > SETTLE) ? WE_CYCLES : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_RUN, S_HOLD_WAIT, S_PSETTLE, S_PROG, S_WRITE, S_RSETTLE
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_WE, PH_HOLD} phase_t;

  state_t            r_state;
  phase_t            r_phase;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_mode_pipe;
  logic [2:0]        r_wr_pipe;
  logic              r_cpu_hold;
  logic              r_wr_ack;
  logic              r_mux_select;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic              r_ram_we_n;
  logic              r_mode_prog;

  logic w_mode_s;
  logic w_wr_rise;
  logic w_cnt_last;

  // Two-flop synchronizers; the wr pipe carries one extra stage for edge detection.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_mode_pipe <= '0;
      r_wr_pipe   <= '0;
    end else begin
      r_mode_pipe <= {r_mode_pipe[0], mode_req};
      r_wr_pipe   <= {r_wr_pipe[1:0], wr_req};
    end
  end

  assign w_mode_s   = r_mode_pipe[1];
  assign w_wr_rise  = r_wr_pipe[1] & ~r_wr_pipe[2];
  assign w_cnt_last = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state      <= S_RUN;
      r_phase      <= PH_SETUP;
      r_cnt        <= '0;
      r_cpu_hold   <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_mux_select <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_ram_we_n   <= 1'b1;
      r_mode_prog  <= 1'b0;
    end else begin
      r_wr_ack <= 1'b0;
      // Address tracks the mux side, but must not move under an in-flight write.
      if (r_state != S_WRITE)
        r_ram_addr <= r_mux_select ? sw_addr : mar_addr;

      unique case (r_state)
        S_RUN: begin
          if (w_mode_s) begin
            r_state    <= S_HOLD_WAIT;
            r_cpu_hold <= 1'b1;
          end
        end
        S_HOLD_WAIT: begin
          if (!w_mode_s) begin
            r_state    <= S_RUN;
            r_cpu_hold <= 1'b0;
          end else if (cpu_idle) begin
            r_state      <= S_PSETTLE;
            r_mux_select <= 1'b1;
            r_mode_prog  <= 1'b1;
            r_cnt        <= CNT_W'(SETTLE);
          end
        end
        S_PSETTLE: begin
          if (w_cnt_last) r_state <= S_PROG;
          else            r_cnt   <= r_cnt - CNT_W'(1);
        end
        S_PROG: begin
          if (w_wr_rise) begin
            r_state    <= S_WRITE;
            r_phase    <= PH_SETUP;
            r_ram_addr <= sw_addr;
            r_ram_din  <= sw_data;
          end else if (!w_mode_s) begin
            r_state      <= S_RSETTLE;
            r_mux_select <= 1'b0;
            r_mode_prog  <= 1'b0;
            r_cnt        <= CNT_W'(SETTLE);
          end
        end
        S_WRITE: begin
          unique case (r_phase)
            PH_SETUP: begin
              r_phase    <= PH_WE;
              r_ram_we_n <= 1'b0;
              r_cnt      <= CNT_W'(WE_CYCLES);
            end
            PH_WE: begin
              if (w_cnt_last) begin
                r_phase    <= PH_HOLD;
                r_ram_we_n <= 1'b1;
              end else begin
                r_cnt <= r_cnt - CNT_W'(1);
              end
            end
            default: begin
              r_state  <= S_PROG;
              r_wr_ack <= 1'b1;
            end
          endcase
        end
        S_RSETTLE: begin
          if (w_cnt_last) begin
            r_state    <= S_RUN;
            r_cpu_hold <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign cpu_hold   = r_cpu_hold;
  assign wr_ack     = r_wr_ack;
  assign mux_select = r_mux_select;
  assign ram_addr   = r_ram_addr;
  assign ram_din    = r_ram_din;
  assign ram_we_n   = r_ram_we_n;
  assign mode_prog  = r_mode_prog;

endmodule

// File: tb/tb_sap_ram_load_ctrl.sv
// Bench for sap_ram_load_ctrl: directed mode/reset sequences plus randomized manual
// writes, with a bus monitor scoring every RAM write against an expected-write queue.
module tb_sap_ram_load_ctrl;
  localparam int AW = 4, DW = 8, WEC = 2, ST = 1;

  logic          clk = 1'b0;
  logic          clr_n, mode_req, cpu_idle, wr_req;
  logic [AW-1:0] mar_addr, sw_addr;
  logic [DW-1:0] sw_data;
  logic          cpu_hold, wr_ack, mux_select, ram_we_n, mode_prog;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;

  sap_ram_load_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WE_CYCLES(WEC), .SETTLE(ST)) dut (
    .clk(clk), .clr_n(clr_n), .mode_req(mode_req), .cpu_idle(cpu_idle), .cpu_hold(cpu_hold),
    .mar_addr(mar_addr), .sw_addr(sw_addr), .sw_data(sw_data), .wr_req(wr_req),
    .wr_ack(wr_ack), .mux_select(mux_select), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we_n(ram_we_n), .mode_prog(mode_prog)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t           exp_q[$];
  logic [DW-1:0] mem_model [16];
  logic [DW-1:0] dut_mem   [16];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: each write must show 1 stable setup cycle, WEC low cycles, 1 stable
  // hold cycle, then exactly one wr_ack, and must match the next expected write.
  logic          m_prev_we = 1'b1;
  logic [AW-1:0] m_prev_addr = '0, m_cap_addr = '0;
  logic [DW-1:0] m_prev_din = '0, m_cap_din = '0;
  int            m_low = 0;
  bit            m_pend = 1'b0;
  wr_t           m_e;

  initial forever begin
    @(negedge clk);
    if (!clr_n) begin
      m_prev_we = 1'b1; m_low = 0; m_pend = 1'b0;
    end else begin
      if (m_pend) begin
        chk("wr_ack_pulse", 32'(wr_ack), 1);
        chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          chk("sb_addr", 32'(m_cap_addr), 32'(m_e.addr));
          chk("sb_data", 32'(m_cap_din), 32'(m_e.data));
          dut_mem[m_cap_addr] = m_cap_din;
        end
        m_pend = 1'b0;
      end else begin
        chk("no_spurious_ack", 32'(wr_ack), 0);
      end
      if (!ram_we_n) begin
        chk("we_only_when_loader", 32'({mux_select, mode_prog}), 3);
        if (m_prev_we) begin
          chk("setup_addr", 32'(m_prev_addr), 32'(ram_addr));
          chk("setup_din", 32'(m_prev_din), 32'(ram_din));
          m_cap_addr = ram_addr; m_cap_din = ram_din; m_low = 1;
        end else begin
          m_low++;
          chk("we_addr_stable", 32'(ram_addr), 32'(m_cap_addr));
          chk("we_din_stable", 32'(ram_din), 32'(m_cap_din));
        end
      end else if (!m_prev_we) begin
        chk("we_low_len", 32'(m_low), WEC);
        chk("hold_addr", 32'(ram_addr), 32'(m_cap_addr));
        chk("hold_din", 32'(ram_din), 32'(m_cap_din));
        m_pend = 1'b1;
      end
      m_prev_we = ram_we_n; m_prev_addr = ram_addr; m_prev_din = ram_din;
    end
  end

  int            we_lo, len;
  bit            got, flag_a, flag_b;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;

  // Press the write button for 'len' cycles; returns WE-low cycles seen and ack status.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int plen,
                          output int lo, output bit ack);
    sw_addr = a; sw_data = d;
    exp_q.push_back('{a, d});
    mem_model[a] = d;
    wr_req = 1'b1; lo = 0; ack = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (!ram_we_n) lo++;
      if (wr_ack) ack = 1'b1;
      if (c >= plen) wr_req = 1'b0;
      if (ack && c >= plen) break;
    end
    wr_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    clr_n = 1'b0; mode_req = 1'b1; wr_req = 1'b1; cpu_idle = 1'b0;
    mar_addr = 4'h3; sw_addr = 4'hA; sw_data = '0;
    for (int i = 0; i < 16; i++) begin mem_model[i] = '0; dut_mem[i] = '0; end
    repeat (3) tick();

    // Reset values, then mode entry with CPU busy.
    chk("rst_mux", 32'(mux_select), 0);
    chk("rst_hold", 32'(cpu_hold), 0);
    chk("rst_we_n", 32'(ram_we_n), 1);
    chk("rst_ack", 32'(wr_ack), 0);
    chk("rst_prog", 32'(mode_prog), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_din", 32'(ram_din), 0);
    clr_n = 1'b1;
    tick(); tick();
    chk("t1_hold_edge2", 32'(cpu_hold), 0);
    tick();
    chk("t1_hold_edge3", 32'(cpu_hold), 1);
    chk("t1_mux", 32'(mux_select), 0);
    wr_req = 1'b0;
    repeat (4) tick();
    chk("t1_hold_wait_hold", 32'(cpu_hold), 1);
    chk("t1_hold_wait_mux", 32'(mux_select), 0);
    chk("t1_hold_wait_prog", 32'(mode_prog), 0);
    chk("t1_addr_mar", 32'(ram_addr), 32'(4'h3));

    // Loader takes the RAM once the CPU is idle.
    cpu_idle = 1'b1;
    tick();
    chk("t2_mux", 32'(mux_select), 1);
    chk("t2_prog", 32'(mode_prog), 1);
    chk("t2_addr_old", 32'(ram_addr), 32'(4'h3));
    tick();
    chk("t2_addr_sw", 32'(ram_addr), 32'(4'hA));
    chk("t2_hold", 32'(cpu_hold), 1);
    cpu_idle = 1'b0;

    // Directed write with a 5-cycle press.
    do_write(4'h5, 8'h2C, 5, we_lo, got);
    chk("t3_ack", 32'(got), 1);
    chk("t3_we_cycles", 32'(we_lo), WEC);
    chk("t3_din", 32'(ram_din), 32'(8'h2C));

    // Randomized writes; long presses must not repeat the write.
    for (int n = 0; n < 24; n++) begin
      ra = AW'($urandom_range(0, 15));
      rd = DW'($urandom_range(0, 255));
      len = $urandom_range(1, 12);
      mar_addr = AW'($urandom);
      do_write(ra, rd, len, we_lo, got);
      chk("rnd_ack", 32'(got), 1);
      chk("rnd_we_cycles", 32'(we_lo), WEC);
    end

    // Mode drop during the WE phase is deferred until after the write.
    mar_addr = 4'hC; sw_addr = 4'h9; sw_data = 8'h5A;
    exp_q.push_back('{4'h9, 8'h5A});
    mem_model[9] = 8'h5A;
    wr_req = 1'b1; got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (!ram_we_n) begin got = 1'b1; break; end
    end
    chk("t4_we_seen", 32'(got), 1);
    mode_req = 1'b0; got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (wr_ack) begin got = 1'b1; break; end
    end
    chk("t4_ack", 32'(got), 1);
    wr_req = 1'b0;
    tick();
    chk("t4_mux_drop", 32'(mux_select), 0);
    chk("t4_prog_drop", 32'(mode_prog), 0);
    chk("t4_hold_still", 32'(cpu_hold), 1);
    tick();
    chk("t4_hold_release", 32'(cpu_hold), 0);
    chk("t4_addr_mar", 32'(ram_addr), 32'(4'hC));

    // Cancel before the CPU goes idle.
    cpu_idle = 1'b0; repeat (2) tick();
    mode_req = 1'b1; flag_a = 1'b0; flag_b = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (mux_select) flag_a = 1'b1;
      if (!ram_we_n) flag_b = 1'b1;
    end
    chk("t5_hold_on", 32'(cpu_hold), 1);
    mode_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (mux_select) flag_a = 1'b1;
      if (!ram_we_n) flag_b = 1'b1;
    end
    chk("t5_hold_off", 32'(cpu_hold), 0);
    chk("t5_mux_never", 32'(flag_a), 0);
    chk("t5_we_never", 32'(flag_b), 0);

    repeat (2) tick();
    chk("sb_drained", 32'(exp_q.size()), 0);
    for (int i = 0; i < 16; i++) chk("mem_image", 32'(dut_mem[i]), 32'(mem_model[i]));

    // Async reset in the middle of the WE phase.
    mode_req = 1'b1; cpu_idle = 1'b1; got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mode_prog) begin got = 1'b1; break; end
    end
    chk("t6_prog", 32'(got), 1);
    repeat (2) tick();
    sw_addr = 4'h7; sw_data = 8'hE1;
    exp_q.push_back('{4'h7, 8'hE1});
    wr_req = 1'b1; got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!ram_we_n) begin got = 1'b1; break; end
    end
    chk("t6_we_seen", 32'(got), 1);
    #2 clr_n = 1'b0;
    #1;
    chk("t6_we_n_async", 32'(ram_we_n), 1);
    chk("t6_mux_async", 32'(mux_select), 0);
    chk("t6_prog_async", 32'(mode_prog), 0);
    chk("t6_hold_async", 32'(cpu_hold), 0);
    exp_q.delete();
    wr_req = 1'b0; mode_req = 1'b0;
    repeat (2) tick();
    clr_n = 1'b1; flag_a = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (wr_ack) flag_a = 1'b1;
    end
    chk("t6_no_ack", 32'(flag_a), 0);
    chk("t6_we_idle", 32'(ram_we_n), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sap_ram_load_ctrl.md
Name: sap_ram_load_ctrl

Overview:
- Controller for the SAP-1 2:1 address multiplexer (74LS157 equivalent) in front of the 16x8 program RAM.
- Shares the RAM between two requesters: the CPU, which drives the address through the MAR, and the manual loader, which uses the address/data switches and a write button.
- Drives the mux select and the RAM write strobe.
- Holds the CPU while the loader owns the RAM and enforces setup/hold timing around each manual write.

Parameters:
ADDR_W, 4, RAM address width (MAR and switch address)
DATA_W, 8, RAM data width
WE_CYCLES, 2, clock cycles ram_we_n is held low per write (>=1)
SETTLE, 1, mux settle cycles after each select change (>=1)

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous active-low reset
mode_req  in  1  program/run switch; 1 = program; asynchronous, synchronized internally
cpu_idle  in  1  CPU halted or at an instruction boundary; safe to take the RAM
cpu_hold  out  1  freezes the CPU ring counter
mar_addr  in  ADDR_W  MAR address (mux input A)
sw_addr  in  ADDR_W  manual address switches (mux input B)
sw_data  in  DATA_W  manual data switches
wr_req  in  1  write button; asynchronous level, synchronized internally
wr_ack  out  1  one-cycle pulse when a manual write completes
mux_select  out  1  157 select; 0 = A (MAR), 1 = B (switches)
ram_addr  out  ADDR_W  registered RAM address
ram_din  out  DATA_W  registered RAM write data
ram_we_n  out  1  RAM write enable, active low
mode_prog  out  1  status: 1 while the loader owns the RAM

Behaviour:
- Clocking and reset: one clock (clk). clr_n is asynchronous and active-low.
- Reset values:
  - state = RUN
  - mux_select = 0, cpu_hold = 0, ram_we_n = 1, wr_ack = 0, mode_prog = 0
  - ram_addr = 0, ram_din = 0
  - all synchronizer and edge flops = 0
- Reset mid-write: ram_we_n goes to 1 immediately, without waiting for a clock edge.
- Synchronization:
  - mode_req and wr_req each pass through 2 flip-flops (mode_s, wr_s).
  - wr_rise = wr_s & ~wr_s_d, where wr_s_d is wr_s delayed by one cycle.
  - A change on mode_req reaches the state register on the 3rd rising edge after it.
- ram_addr selection: ram_addr registers mar_addr when mux_select = 0 and sw_addr when mux_select = 1, except that it is frozen during WRITE.
- State RUN:
  - mux_select = 0, cpu_hold = 0.
  - If mode_s = 1, go to HOLD_WAIT and set cpu_hold = 1.
- State HOLD_WAIT:
  - cpu_hold = 1.
  - If mode_s = 0, go to RUN and release cpu_hold. This is a cancel.
  - Else if cpu_idle = 1, set mux_select = 1 and mode_prog = 1, load the counter with SETTLE, and go to PSETTLE.
- State PSETTLE: count down SETTLE cycles, then go to PROG. wr_rise is ignored while in this state.
- State PROG:
  - On wr_rise, latch ram_addr <= sw_addr and ram_din <= sw_data, then go to WRITE.
  - Else if mode_s = 0, set mux_select = 0 and mode_prog = 0, load the counter with SETTLE, and go to RSETTLE.
  - wr_rise has priority over a simultaneous mode drop.
- State WRITE, with phases:
  - 1 setup cycle with ram_we_n = 1.
  - WE_CYCLES cycles with ram_we_n = 0.
  - 1 hold cycle with ram_we_n = 1.
  - Then go to PROG with wr_ack = 1 for that one cycle.
  - Address and data stay constant for the whole write.
  - A mode drop during WRITE is deferred until the write completes; no truncated writes.
  - Holding wr_req high does not repeat the write; a new write needs release and re-press.
- State RSETTLE:
  - cpu_hold stays 1 for SETTLE cycles, then go to RUN and set cpu_hold = 0.
  - A mode_s rise here is handled only after reaching RUN.
- ram_we_n is 0 only in the WE phase of WRITE, never in any other state.
- mux_select changes only on the HOLD_WAIT->PSETTLE and PROG->RSETTLE transitions.

Test Plan:
1. Reset: clr_n = 0 with wr_req = 1 and mode_req = 1 -> all outputs at reset values. Release reset with cpu_idle = 0 -> cpu_hold = 1 on the 3rd edge, mux_select stays 0, state stays HOLD_WAIT.
2. Mode entry: mode_req = 1, cpu_idle = 1, mar_addr = 4'h3, sw_addr = 4'hA -> mux_select = 1 one cycle after cpu_hold, ram_addr = 4'hA after SETTLE+1 cycles, mode_prog = 1.
3. Write: in PROG, sw_addr = 4'h5, sw_data = 8'h2C, pulse wr_req for 5 cycles -> exactly one write: ram_we_n low for exactly 2 cycles, preceded by 1 and followed by 1 cycle of stable addr 5 / data 2C, then a single wr_ack pulse.
4. Mode drop during write: drop mode_req during the WE phase -> the write completes unchanged, then mux_select = 0 after wr_ack, cpu_hold releases SETTLE cycles later, ram_addr follows mar_addr.
5. Cancel: mode_req = 1 then back to 0 before cpu_idle is asserted -> cpu_hold drops, mux_select never leaves 0, ram_we_n stays 1 throughout.
6. Async reset mid-write: assert clr_n = 0 while ram_we_n = 0 -> ram_we_n = 1 and mux_select = 0 immediately, with no clock edge; no wr_ack is produced.
